// File: rtl/clk_en_monitor.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_monitor
// Description : Watches a periodic single-cycle clock-enable strobe, measures
//               its period in clk cycles, declares lock after a run of equal
//               intervals, and flags interval mismatches and strobe loss.
// Ports       : clk        - system clock
//               reset      - synchronous active-high reset
//               strobe_in  - enable strobe, sampled every rising edge
//               locked     - period has been stable long enough
//               period     - locked period (qualify with locked)
//               phase      - cycles since last strobe, saturating
//               mismatch   - one-cycle pulse, interval differed
//               timeout    - one-cycle pulse, strobe lost
// Revision    : 1.0 - initial release
// ============================================================================
module clk_en_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int MAX_PERIOD = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe_in,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] phase,
    output logic             mismatch,
    output logic             timeout
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FIRST  = 2'd1;
    localparam logic [1:0] c_TRACK  = 2'd2;
    localparam logic [1:0] c_LOCKED = 2'd3;

    localparam logic [CNT_W-1:0] c_MAX  = CNT_W'(MAX_PERIOD);
    localparam logic [3:0]       c_LOCK = 4'(LOCK_COUNT);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] cand_q, cand_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             locked_q, locked_d;
    logic             mismatch_q, mismatch_d;
    logic             timeout_q, timeout_d;

    logic [CNT_W-1:0] w_phase_inc;
    logic [3:0]       w_match_next;

    assign w_phase_inc  = (phase_q == c_MAX) ? c_MAX : phase_q + CNT_W'(1);
    assign w_match_next = match_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cand_d      = cand_q;
        match_cnt_d = match_cnt_q;
        period_d    = period_q;
        locked_d    = locked_q;
        mismatch_d  = 1'b0;
        timeout_d   = 1'b0;

        if (state_q == c_IDLE) begin
            // Phase stays parked at zero until the first strobe arms the
            // counter; that strobe starts the first interval at 1.
            phase_d = '0;
            if (strobe_in) begin
                state_d = c_FIRST;
                phase_d = CNT_W'(1);
            end
        end else if (strobe_in) begin
            // A strobe always wins over a simultaneous saturated phase, so
            // an interval of exactly MAX_PERIOD is measurable.
            phase_d = CNT_W'(1);
            case (state_q)
                c_FIRST: begin
                    state_d     = c_TRACK;
                    cand_d      = phase_q;
                    match_cnt_d = 4'd0;
                end
                c_TRACK: begin
                    if (phase_q == cand_q) begin
                        match_cnt_d = w_match_next;
                        if (w_match_next == c_LOCK) begin
                            state_d  = c_LOCKED;
                            period_d = cand_q;
                            locked_d = 1'b1;
                        end
                    end else begin
                        mismatch_d  = 1'b1;
                        cand_d      = phase_q;
                        match_cnt_d = 4'd0;
                    end
                end
                default: begin
                    if (phase_q != period_q) begin
                        mismatch_d  = 1'b1;
                        locked_d    = 1'b0;
                        state_d     = c_TRACK;
                        cand_d      = phase_q;
                        match_cnt_d = 4'd0;
                    end
                end
            endcase
        end else if (phase_q == c_MAX) begin
            // Strobe lost: drop back to idle. period keeps its old value.
            timeout_d   = 1'b1;
            state_d     = c_IDLE;
            locked_d    = 1'b0;
            phase_d     = '0;
            match_cnt_d = 4'd0;
        end else begin
            phase_d = w_phase_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= c_IDLE;
            phase_q     <= '0;
            cand_q      <= '0;
            match_cnt_q <= 4'd0;
            period_q    <= '0;
            locked_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cand_q      <= cand_d;
            match_cnt_q <= match_cnt_d;
            period_q    <= period_d;
            locked_q    <= locked_d;
            mismatch_q  <= mismatch_d;
            timeout_q   <= timeout_d;
        end
    end

    assign locked   = locked_q;
    assign period   = period_q;
    assign phase    = phase_q;
    assign mismatch = mismatch_q;
    assign timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_en_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_en_monitor
// Description : Self-checking bench for clk_en_monitor. A driver issues
//               directed and random strobe patterns, advances a reference
//               model built on run lengths of equal intervals, and queues the
//               expected outputs; a monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_en_monitor;

    localparam int CNT_W      = 8;
    localparam int LOCK_COUNT = 4;
    localparam int MAX_PERIOD = 255;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             strobe_in = 1'b0;
    logic             locked;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] phase;
    logic             mismatch;
    logic             timeout;

    clk_en_monitor #(
        .CNT_W      (CNT_W),
        .LOCK_COUNT (LOCK_COUNT),
        .MAX_PERIOD (MAX_PERIOD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .strobe_in (strobe_in),
        .locked    (locked),
        .period    (period),
        .phase     (phase),
        .mismatch  (mismatch),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit locked;
        int period;
        int phase;
        bit mismatch;
        bit timeout;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: "armed" once a strobe has been seen, the elapsed
    // time since the last strobe, and the length of the current run of
    // equal intervals.
    bit m_armed;
    int m_since;
    bit m_have_int;
    int m_run_val;
    int m_run_len;
    bit m_locked;
    int m_period;
    bit m_mis;
    bit m_to;

    function automatic int m_phase();
        if (!m_armed) return 0;
        return (m_since > MAX_PERIOD) ? MAX_PERIOD : m_since;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit s, input bit r);
        int iv;
        m_mis = 1'b0;
        m_to  = 1'b0;
        if (r) begin
            m_armed = 1'b0; m_since = 0; m_have_int = 1'b0;
            m_run_val = 0; m_run_len = 0; m_locked = 1'b0; m_period = 0;
        end else if (!m_armed) begin
            if (s) begin
                m_armed = 1'b1; m_since = 1; m_have_int = 1'b0;
            end
        end else if (s) begin
            iv = m_phase();
            if (!m_have_int) begin
                m_have_int = 1'b1; m_run_val = iv; m_run_len = 1;
            end else if (m_locked) begin
                if (iv != m_period) begin
                    m_mis = 1'b1; m_locked = 1'b0; m_run_val = iv; m_run_len = 1;
                end
            end else if (iv == m_run_val) begin
                m_run_len++;
                if (m_run_len == LOCK_COUNT + 1) begin
                    m_locked = 1'b1; m_period = iv;
                end
            end else begin
                m_mis = 1'b1; m_run_val = iv; m_run_len = 1;
            end
            m_since = 1;
        end else if (m_phase() == MAX_PERIOD) begin
            m_to = 1'b1; m_armed = 1'b0; m_locked = 1'b0; m_since = 0;
        end else begin
            m_since++;
        end
    endtask

    // One clock cycle of stimulus: drive inputs away from the active edge,
    // predict the post-edge outputs and queue them.
    task automatic step(input bit s, input bit r);
        exp_t e;
        @(negedge clk);
        strobe_in = s;
        reset     = r;
        model_edge(s, r);
        e.locked   = m_locked;
        e.period   = m_period;
        e.phase    = m_phase();
        e.mismatch = m_mis;
        e.timeout  = m_to;
        sb_q.push_back(e);
    endtask

    task automatic interval(input int p);
        repeat (p - 1) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
    endtask

    // Monitor: compares DUT outputs against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("locked",   {31'b0, locked},   {31'b0, e.locked});
                check("period",   {24'b0, period},   32'(e.period));
                check("phase",    {24'b0, phase},    32'(e.phase));
                check("mismatch", {31'b0, mismatch}, {31'b0, e.mismatch});
                check("timeout",  {31'b0, timeout},  {31'b0, e.timeout});
            end
        end
    end

    initial begin
        int p;
        int n;
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        // Divide-by-3 lock, then a glitch and relock.
        step(1'b1, 1'b0);
        repeat (5) interval(3);
        interval(2);
        repeat (6) interval(3);

        // Strobe loss, then restart with a new period.
        repeat (300) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (6) interval(5);

        // Reset while tracking with three matches, strobe in reset cycle.
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (4) interval(4);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        repeat (5) interval(4);

        // Constant-high strobe.
        step(1'b0, 1'b1);
        repeat (12) step(1'b1, 1'b0);

        // Interval of exactly MAX_PERIOD, then one too long.
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (6) interval(MAX_PERIOD);
        interval(MAX_PERIOD + 1);
        repeat (3) step(1'b0, 1'b0);

        // Random segments with occasional glitches, gaps and resets.
        repeat (60) begin
            p = $urandom_range(1, 7);
            n = $urandom_range(1, 9);
            repeat (n) begin
                if ($urandom_range(0, 9) == 0) interval($urandom_range(1, 8));
                else interval(p);
            end
            case ($urandom_range(0, 9))
                0: step($urandom_range(0, 1) == 1, 1'b1);
                1: repeat ($urandom_range(250, 262)) step(1'b0, 1'b0);
                default: ;
            endcase
        end
        step(1'b0, 1'b0);

        @(posedge clk);
        #2;
        check("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
